// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command/response handshake between EEPROM sequencer and I2C byte engine
interface i2c_byte_master_if;
  logic [2:0] command;
  logic [7:0] wr_data;
  logic       busy;
  logic       error;
  logic [7:0] rd_data;

  modport master (output command, output wr_data, input busy, input error, input rd_data);
  modport slave  (input command, input wr_data, output busy, output error, output rd_data);
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level open-drain I2C master engine (START, byte, ACK, optional STOP)
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               sda,
  inout  wire               scl,
  i2c_byte_master_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GUARD} state_e;

  state_e     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [2:0] cmd_q, cmd_d;
  logic       error_q, error_d;
  logic       bus_held_q, bus_held_d;

  logic sda_oe, scl_oe;
  logic busy, hold, div_end, qtr_end, elem_end, sample, is_write;

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

  assign busy     = (state_q == S_START) || (state_q == S_BIT) ||
                    (state_q == S_ACK)   || (state_q == S_STOP);
  assign is_write = cmd_q[1];

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low after we release it freezes the quarter timer.
  assign hold = ((state_q == S_BIT) || (state_q == S_ACK) || (state_q == S_STOP)) &&
                (qtr_q == 2'd1) && !scl;
`else
  assign hold = 1'b0;
`endif

  assign div_end  = (div_q == 8'(CLK_DIV - 1));
  assign qtr_end  = div_end && !hold;
  assign elem_end = qtr_end && (qtr_q == 2'd3);
  assign sample   = div_end && (qtr_q == 2'd2);

  assign bus.busy    = busy;
  assign bus.error   = error_q;
  assign bus.rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      qtr_q      <= 2'd0;
      div_q      <= 8'd0;
      bit_q      <= 3'd0;
      sr_q       <= 8'd0;
      rd_data_q  <= 8'd0;
      cmd_q      <= 3'd0;
      error_q    <= 1'b0;
      bus_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      rd_data_q  <= rd_data_d;
      cmd_q      <= cmd_d;
      error_q    <= error_d;
      bus_held_q <= bus_held_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    rd_data_d  = rd_data_q;
    cmd_d      = cmd_q;
    error_d    = error_q;
    bus_held_d = bus_held_q;
    if (busy) begin
      if (qtr_end) begin
        div_d = 8'd0;
        qtr_d = qtr_q + 2'd1;
      end else if (!hold) begin
        div_d = div_q + 8'd1;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (bus.command[0]) begin
          cmd_d   = bus.command;
          sr_d    = bus.wr_data;
          error_d = 1'b0;
          bit_d   = 3'd0;
          div_d   = 8'd0;
          qtr_d   = 2'd0;
          state_d = bus_held_q ? S_BIT : S_START;
        end
      end
      S_START: if (elem_end) state_d = S_BIT;
      S_BIT: begin
        if (sample && !is_write) sr_d = {sr_q[6:0], sda};
        if (elem_end) begin
          if (is_write) sr_d = {sr_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (sample && is_write && sda) error_d = 1'b1;
        if (elem_end) begin
          if (!is_write) rd_data_d = sr_q;
          // A NACKed write always releases the bus.
          if (cmd_q[2] || error_q) begin
            state_d = S_STOP;
          end else begin
            state_d    = S_GUARD;
            bus_held_d = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (elem_end) begin
          state_d    = S_GUARD;
          bus_held_d = 1'b0;
        end
      end
      S_GUARD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sda_oe = 1'b0;
    scl_oe = 1'b0;
    case (state_q)
      S_IDLE, S_GUARD: scl_oe = bus_held_q;
      S_START: begin
        sda_oe = (qtr_q >= 2'd2);
        scl_oe = (qtr_q == 2'd3);
      end
      S_BIT: begin
        sda_oe = is_write && !sr_q[7];
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      end
      S_ACK: begin
        sda_oe = !is_write && !cmd_q[2];
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      end
      S_STOP: begin
        sda_oe = (qtr_q <= 2'd1);
        scl_oe = (qtr_q == 2'd0);
      end
      default: begin
        sda_oe = 1'b0;
        scl_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - directed bench with bus-level slave model and transfer scoreboard
module tb_i2c_byte_master;

  typedef struct packed {
    logic       start;
    logic [7:0] data;
    logic       ack;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  sda;
  wire  scl;
  logic slv_sda_low = 1'b0;
  logic slv_scl_low = 1'b0;

  pullup (sda);
  pullup (scl);
  assign sda = slv_sda_low ? 1'b0 : 1'bz;
  assign scl = slv_scl_low ? 1'b0 : 1'bz;

  i2c_byte_master_if bus ();

  i2c_byte_master #(.CLK_DIV(1)) dut (
    .clk (clk),
    .rst (rst),
    .sda (sda),
    .scl (scl),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  xfer_t exp_q[$];
  xfer_t obs_q[$];

  // Slave model: 0 = ACK writes, 1 = absent, 2 = return rd_byte on reads
  int         mode = 0;
  logic [7:0] rd_byte = 8'h00;
  logic       prev_sda = 1'b1;
  logic       prev_scl = 1'b1;
  int         nbits = 0;
  logic [7:0] shreg = 8'h00;
  logic       ackbit = 1'b1;
  logic       got_start = 1'b0;
  logic       dead = 1'b0;
  int         stop_cnt = 0;

  always @(negedge clk) begin
    if (scl && prev_scl && prev_sda && !sda) begin
      got_start = 1'b1;
      nbits     = 0;
      dead      = 1'b0;
    end
    if (scl && prev_scl && !prev_sda && sda) stop_cnt++;
    if (scl && !prev_scl) begin
      if (nbits < 8) shreg = {shreg[6:0], sda};
      else begin
        ackbit = sda;
        if (mode == 2 && sda) dead = 1'b1;
      end
      nbits++;
    end
    if (!scl && prev_scl && nbits == 9) begin
      obs_q.push_back('{start: got_start, data: shreg, ack: ackbit});
      got_start = 1'b0;
      nbits     = 0;
    end
    if (!scl)
      slv_sda_low = !dead && ((mode == 0 && nbits == 8) ||
                              (mode == 2 && nbits < 8 && !rd_byte[3'(7 - nbits)]));
    prev_sda = sda;
    prev_scl = scl;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_sb(input string tag);
    xfer_t e;
    xfer_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing"}, 32'hDEAD, 32'(e));
      end else begin
        o = obs_q.pop_front();
        check(tag, 32'(o), 32'(e));
      end
    end
    check({tag, "_extra"}, obs_q.size(), 0);
  endtask

  // Called at a negedge; returns accept latency, busy high-time and error right after accept.
  task automatic run_cmd(input logic [2:0] cmd, input logic [7:0] data, input int stretch_at,
                         output int lat, output int len, output logic err_first);
    bus.command = cmd;
    bus.wr_data = data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.busy && lat < 10);
    check("accept_busy", {31'b0, bus.busy}, 32'd1);
    bus.command = 3'b000;
    err_first   = bus.error;
    len = 0;
    while (bus.busy && len < 300) begin
      if (len == stretch_at) slv_scl_low = 1'b1;
      if (len == stretch_at + 11) slv_scl_low = 1'b0;
      len++;
      @(negedge clk);
    end
    slv_scl_low = 1'b0;
  endtask

  initial begin
    int   lat;
    int   len;
    int   n;
    int   stop_base;
    logic ef;
    logic seen;

    bus.command = 3'b000;
    bus.wr_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_error", {31'b0, bus.error}, 0);
    check("rst_rd_data", {24'b0, bus.rd_data}, 0);
    check("rst_sda", {31'b0, sda}, 1);
    check("rst_scl", {31'b0, scl}, 1);
    obs_q.delete();

    // Write 0xA0 on a free bus, no STOP
    mode = 0;
    exp_q.push_back('{start: 1'b1, data: 8'hA0, ack: 1'b0});
    run_cmd(3'b011, 8'hA0, 1000, lat, len, ef);
    check("w1_lat", lat, 1);
    check("w1_len", len, 40);
    check("w1_error", {31'b0, bus.error}, 0);
    check("w1_scl_held", {31'b0, scl}, 0);
    check("w1_sda", {31'b0, sda}, 1);
    check_sb("w1_sb");

    // Continue on held bus with STOP, issued while GUARD is active
    stop_base = stop_cnt;
    exp_q.push_back('{start: 1'b0, data: 8'h00, ack: 1'b0});
    run_cmd(3'b111, 8'h00, 1000, lat, len, ef);
    check("w2_guard_lat", lat, 2);
    check("w2_len", len, 40);
    check("w2_stop", stop_cnt - stop_base, 1);
    check("w2_lines", {30'b0, sda, scl}, 3);
    check_sb("w2_sb");

    // Read with NACK and STOP
    mode = 2;
    rd_byte = 8'h5A;
    stop_base = stop_cnt;
    exp_q.push_back('{start: 1'b1, data: 8'h5A, ack: 1'b1});
    run_cmd(3'b101, 8'h00, 1000, lat, len, ef);
    check("rd_len", len, 44);
    check("rd_data", {24'b0, bus.rd_data}, 32'h5A);
    check("rd_stop", stop_cnt - stop_base, 1);
    check("rd_lines", {30'b0, sda, scl}, 3);
    check_sb("rd_sb");

    // Write with no slave: NACK forces STOP
    mode = 1;
    stop_base = stop_cnt;
    exp_q.push_back('{start: 1'b1, data: 8'h3C, ack: 1'b1});
    run_cmd(3'b011, 8'h3C, 1000, lat, len, ef);
    check("nack_len", len, 44);
    check("nack_error", {31'b0, bus.error}, 1);
    check("nack_stop", stop_cnt - stop_base, 1);
    check("nack_lines", {30'b0, sda, scl}, 3);
    check_sb("nack_sb");

    // Next accept clears error
    mode = 0;
    exp_q.push_back('{start: 1'b1, data: 8'hC3, ack: 1'b0});
    run_cmd(3'b111, 8'hC3, 1000, lat, len, ef);
    check("clr_err_at_accept", {31'b0, ef}, 0);
    check("clr_len", len, 44);
    check("clr_error", {31'b0, bus.error}, 0);
    check_sb("clr_sb");

    // Invalid codes without go are ignored
    seen = 1'b0;
    bus.command = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | bus.busy;
    end
    bus.command = 3'b110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | bus.busy;
    end
    bus.command = 3'b000;
    check("invalid_no_accept", {31'b0, seen}, 0);

    // Reset during bit 3 of a write
    bus.command = 3'b011;
    bus.wr_data = 8'hF0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.busy && n < 10);
    check("rstmid_accept", {31'b0, bus.busy}, 1);
    bus.command = 3'b000;
    for (int i = 0; i < 17; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {31'b0, bus.busy}, 0);
    check("rstmid_lines", {30'b0, sda, scl}, 3);
    check("rstmid_rd_data", {24'b0, bus.rd_data}, 0);
    rst = 1'b0;
    obs_q.delete();
    exp_q.push_back('{start: 1'b1, data: 8'h96, ack: 1'b0});
    run_cmd(3'b011, 8'h96, 1000, lat, len, ef);
    check("rstmid_fresh_len", len, 40);
    check_sb("rstmid_sb");

    // Slave stretches SCL for 10 cycles during bit 5 (held bus, no START)
    stop_base = stop_cnt;
`ifdef I2C_CLK_STRETCH_EN
    exp_q.push_back('{start: 1'b0, data: 8'h55, ack: 1'b0});
    run_cmd(3'b111, 8'h55, 20, lat, len, ef);
    check("stretch_len", len, 50);
    check("stretch_error", {31'b0, bus.error}, 0);
    check_sb("stretch_sb");
`else
    run_cmd(3'b111, 8'h55, 20, lat, len, ef);
    check("stretch_len", len, 40);
    obs_q.delete();
`endif
    check("stretch_stop", stop_cnt - stop_base, 1);
    check("stretch_lines", {30'b0, sda, scl}, 3);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
